mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Shares one backing-memory port between the icache and dcache refill/writeback paths.
//  Sits below the caches feeding the Riscv core; FSM-sequenced, one transaction in flight.
//  Round-robin on contention; all memory-side outputs registered.
// PARAMETERS
//  ADDR_W   32   request address width (line-aligned; low bits passed through unchanged)
//  DATA_W   128  memory line width
// PORTS
//  clk            in   1       clock, all state on rising edge
//  reset          in   1       asynchronous, active-high reset
//  ic_req_valid   in   1       icache read request; held with addr until ic_resp_valid
//  ic_req_addr    in   ADDR_W  icache line address
//  ic_resp_valid  out  1       one-cycle pulse: ic_resp_data valid, request complete
//  ic_resp_data   out  DATA_W  read line for icache
//  dc_req_valid   in   1       dcache request; held with rw/addr/wdata until dc_resp_valid
//  dc_req_rw      in   1       1=write (writeback), 0=read (refill)
//  dc_req_addr    in   ADDR_W  dcache line address
//  dc_req_wdata   in   DATA_W  writeback line
//  dc_resp_valid  out  1       one-cycle pulse: read data valid / write accepted
//  dc_resp_data   out  DATA_W  read line for dcache (don't-care on write completion)
//  mem_req_valid  out  1       request to memory; held until mem_req_ready
//  mem_req_ready  in   1       memory accepts request when valid&ready
//  mem_req_rw     out  1       1=write, 0=read
//  mem_req_addr   out  ADDR_W  latched address of granted requester
//  mem_req_data   out  DATA_W  latched write data (0 for reads)
//  mem_resp_valid in   1       read data return, one cycle, reads only
//  mem_resp_data  in   DATA_W  read line
//  busy           out  1       state != IDLE
//  grant_dc       out  1       current/last grant was dcache (debug)
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; last_dc=0; capture regs 0.
//  States: IDLE -> ISSUE -> (WAIT for reads) -> IDLE.
//  IDLE: eligible = req_valid and not masked; if any eligible, grant, capture rw/addr/wdata
//   into regs, assert mem_req_valid next cycle, go ISSUE. No eligible -> stay IDLE.
//  Arbitration: one eligible -> it wins. Both -> dc wins if last_dc==0, else ic.
//   last_dc <= granted-is-dc at every grant. icache requests always rw=0.
//  ISSUE: mem_req_* stable while mem_req_valid && !mem_req_ready. On valid&ready:
//   write -> go IDLE, pulse dc_resp_valid that same next cycle; read -> go WAIT.
//  WAIT: mem_req_valid=0. On mem_resp_valid: register data into granted resp_data,
//   pulse granted resp_valid next cycle, go IDLE.
//  Latency: req seen in IDLE cycle N -> mem_req_valid at N+1. Accept at M -> write ack
//   at M+1. mem_resp_valid at K -> resp_valid at K+1. Min read 3 cycles with ready=1,
//   resp on the cycle after accept.
//  Masking: in the IDLE cycle where resp_valid pulses, served requester is ineligible
//   (requester still shows the stale request); other requester may be granted.
//  resp_data holds last value until next completion for that requester.
//  mem_resp_valid in IDLE/ISSUE ignored (no state change, no resp pulse).
//  req_valid dropped mid-transaction: transaction still completes and pulses resp.
//  Reset mid-transaction: immediate return to IDLE, mem_req_valid drops asynchronously,
//   in-flight response discarded; no resp pulse issued.
// TESTING
//  ic read alone, ready=1, resp 2 cycles after accept, data 0xA5.. -> ic_resp_valid 1
//   cycle with 0xA5.., mem_req_addr = ic addr, busy low after pulse.
//  ic and dc read asserted same cycle after reset -> dc granted first, ic second
//   (last_dc=1); repeat both -> alternation continues dc,ic,dc,ic.
//  dc write, mem_req_ready low 5 cycles -> mem_req_* stable 5 cycles, dc_resp_valid
//   exactly 1 cycle after handshake, no WAIT entry, ic not granted before ack.
//  Requester holds req 1 cycle past resp pulse -> no duplicate mem request issued.
//  Reset asserted in WAIT, mem_resp_valid arrives after release -> outputs 0, no resp
//   pulse, next ic request served normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Purpose : shares one backing-memory port between icache refills and dcache refill/writeback.
// Latency : grant to mem_req_valid 1 cycle; accept to write ack 1 cycle; mem_resp to resp pulse 1 cycle.
// Backpress: mem_req_* held stable while mem_req_ready is low; requesters hold until their resp pulse.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              reset,
    // icache read port
    input  logic              ic_req_valid,
    input  logic [ADDR_W-1:0] ic_req_addr,
    output logic              ic_resp_valid,
    output logic [DATA_W-1:0] ic_resp_data,
    // dcache read/writeback port
    input  logic              dc_req_valid,
    input  logic              dc_req_rw,
    input  logic [ADDR_W-1:0] dc_req_addr,
    input  logic [DATA_W-1:0] dc_req_wdata,
    output logic              dc_resp_valid,
    output logic [DATA_W-1:0] dc_resp_data,
    // backing memory port
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_rw,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_data,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data,
    // status
    output logic              busy,
    output logic              grant_dc
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    // Captured request of the granted requester; drives the memory port directly.
    typedef struct packed {
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } req_t;

    state_t state;
    state_t state_nxt;

    req_t   cap_q;
    req_t   cap_d;
    logic   req_vld_q;
    logic   req_vld_d;
    logic   last_dc;

    logic   ic_elig;
    logic   dc_elig;
    logic   any_elig;
    logic   pick_dc;
    logic   handshake;

    logic   grant_load;
    logic   wr_done;
    logic   rd_done;
    logic   ic_done;
    logic   dc_done;

    // A requester whose response is pulsing this cycle still shows its old request;
    // masking it prevents a duplicate transaction for the same miss.
    assign ic_elig   = ic_req_valid & ~ic_resp_valid;
    assign dc_elig   = dc_req_valid & ~dc_resp_valid;
    assign any_elig  = ic_elig | dc_elig;

    // Round robin: a lone eligible requester wins; on contention the one not served last wins.
    assign pick_dc   = dc_elig & (~ic_elig | ~last_dc);

    assign handshake = req_vld_q & mem_req_ready;

    // Build the capture value for whichever requester wins this cycle.
    always_comb begin
        cap_d = '0;
        if (pick_dc) begin
            cap_d.rw   = dc_req_rw;
            cap_d.addr = dc_req_addr;
            cap_d.data = dc_req_rw ? dc_req_wdata : '0;
        end else begin
            cap_d.rw   = 1'b0;
            cap_d.addr = ic_req_addr;
            cap_d.data = '0;
        end
    end

    // State register; reset aborts any transaction immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: writes finish at the handshake, reads wait for the memory response.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (any_elig) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (handshake) begin
                    state_nxt = cap_q.rw ? S_IDLE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_resp_valid) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode: strobes that update the registered outputs on the next edge.
    always_comb begin
        grant_load = 1'b0;
        req_vld_d  = 1'b0;
        wr_done    = 1'b0;
        rd_done    = 1'b0;
        case (state)
            S_IDLE: begin
                grant_load = any_elig;
                req_vld_d  = any_elig;
            end
            S_ISSUE: begin
                req_vld_d  = ~handshake;
                wr_done    = handshake & cap_q.rw;
            end
            S_WAIT: begin
                rd_done    = mem_resp_valid;
            end
            default: begin
                grant_load = 1'b0;
            end
        endcase
    end

    // Completion routing uses the last grant, which is stable for the whole transaction.
    assign ic_done = rd_done & ~last_dc;
    assign dc_done = wr_done | (rd_done & last_dc);

    // Memory-side request registers and grant history.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_vld_q <= 1'b0;
            cap_q     <= '0;
            last_dc   <= 1'b0;
        end else begin
            req_vld_q <= req_vld_d;
            if (grant_load) begin
                cap_q   <= cap_d;
                last_dc <= pick_dc;
            end
        end
    end

    // Response pulses and per-requester read data; data holds until that requester's next read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ic_resp_valid <= 1'b0;
            dc_resp_valid <= 1'b0;
            ic_resp_data  <= '0;
            dc_resp_data  <= '0;
        end else begin
            ic_resp_valid <= ic_done;
            dc_resp_valid <= dc_done;
            if (ic_done) begin
                ic_resp_data <= mem_resp_data;
            end
            if (rd_done & last_dc) begin
                dc_resp_data <= mem_resp_data;
            end
        end
    end

    assign mem_req_valid = req_vld_q;
    assign mem_req_rw    = cap_q.rw;
    assign mem_req_addr  = cap_q.addr;
    assign mem_req_data  = cap_q.data;

    assign busy          = (state != S_IDLE);
    assign grant_dc      = last_dc;

endmodule
